// File: rtl/boot_flash_spi_initiator.sv
// SPI mode-0 boot-flash initiator: 1..256 byte full-duplex bursts under one CS; CS falls 1 cycle after start, byte period 16*CLK_DIV+1.
// Backpressure: txReady only in LOAD; a txValid stall parks the bus with SCLK low and CS held, no edges.
module boot_flash_spi_initiator #(
   parameter int CLK_DIV = 2
) (
   input  logic       sysClk,
   input  logic       sysReset_n,
   input  logic       start,
   input  logic [8:0] byteCount,
   output logic       busy,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txReady,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       done,
   output logic       spiCsB,
   output logic       spiSclk,
   output logic       spiMosi,
   input  logic       spiMiso
);

   localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOW,
      ST_HIGH,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t     state_q, state_d;
   logic [8:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [8:0] remain_q, remain_d;
   logic [7:0] shift_q, shift_d;
   logic       cs_b_q, cs_b_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       done_q, done_d;

   always_ff @(posedge sysClk) begin
      if (!sysReset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         remain_q   <= '0;
         shift_q    <= '0;
         cs_b_q     <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         remain_q   <= remain_d;
         shift_q    <= shift_d;
         cs_b_q     <= cs_b_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      remain_d   = remain_q;
      shift_d    = shift_q;
      cs_b_d     = cs_b_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && (byteCount != 9'd0)) begin
               remain_d = byteCount;
               cs_b_d   = 1'b0;
               busy_d   = 1'b1;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (txValid) begin
               shift_d = txData;
               mosi_d  = txData[7];
               bit_d   = 3'd0;
               cnt_d   = 9'd0;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = 9'd0;
               sclk_d  = 1'b1;
               state_d = ST_HIGH;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         ST_HIGH: begin
            if (cnt_q == DIV_LAST) begin
               // MISO is sampled on the same edge that drops SCLK, giving the flash the whole bit to settle.
               cnt_d   = 9'd0;
               sclk_d  = 1'b0;
               shift_d = {shift_q[6:0], spiMiso};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  rx_data_d  = {shift_q[6:0], spiMiso};
                  rx_valid_d = 1'b1;
                  remain_d   = remain_q - 9'd1;
                  state_d    = (remain_q == 9'd1) ? ST_HOLD : ST_LOAD;
               end else begin
                  mosi_d  = shift_q[6];
                  state_d = ST_LOW;
               end
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = 9'd0;
               cs_b_d  = 1'b1;
               done_d  = 1'b1;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 9'd0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign txReady = (state_q == ST_LOAD);
   assign busy    = busy_q;
   assign rxData  = rx_data_q;
   assign rxValid = rx_valid_q;
   assign done    = done_q;
   assign spiCsB  = cs_b_q;
   assign spiSclk = sclk_q;
   assign spiMosi = mosi_q;

endmodule

// File: tb/tb_boot_flash_spi_initiator.sv
// Bench for boot_flash_spi_initiator: a CLK_DIV=2 and a CLK_DIV=1 instance, one observed at a time, with a flash model.
module tb_boot_flash_spi_initiator;

   logic       sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   logic       sysReset_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] byteCount = 9'd0;
   logic [7:0] txData = 8'd0;
   logic       txValid = 1'b0;
   logic       sel1 = 1'b0;
   logic       loopback = 1'b0;
   logic [7:0] flash_byte = 8'd0;
   logic [2:0] flash_bit = 3'd0;
   logic       spiMiso;

   logic       a_busy, a_txReady, a_rxValid, a_done, a_spiCsB, a_spiSclk, a_spiMosi;
   logic       b_busy, b_txReady, b_rxValid, b_done, b_spiCsB, b_spiSclk, b_spiMosi;
   logic [7:0] a_rxData, b_rxData;
   logic       busy, txReady, rxValid, done, spiCsB, spiSclk, spiMosi;
   logic [7:0] rxData;
   logic       start_a, start_b;

   assign start_a = start & ~sel1;
   assign start_b = start & sel1;

   boot_flash_spi_initiator #(.CLK_DIV(2)) dut_div2 (
      .sysClk(sysClk), .sysReset_n(sysReset_n), .start(start_a), .byteCount(byteCount),
      .busy(a_busy), .txData(txData), .txValid(txValid), .txReady(a_txReady),
      .rxData(a_rxData), .rxValid(a_rxValid), .done(a_done), .spiCsB(a_spiCsB),
      .spiSclk(a_spiSclk), .spiMosi(a_spiMosi), .spiMiso(spiMiso));

   boot_flash_spi_initiator #(.CLK_DIV(1)) dut_div1 (
      .sysClk(sysClk), .sysReset_n(sysReset_n), .start(start_b), .byteCount(byteCount),
      .busy(b_busy), .txData(txData), .txValid(txValid), .txReady(b_txReady),
      .rxData(b_rxData), .rxValid(b_rxValid), .done(b_done), .spiCsB(b_spiCsB),
      .spiSclk(b_spiSclk), .spiMosi(b_spiMosi), .spiMiso(spiMiso));

   assign busy    = sel1 ? b_busy    : a_busy;
   assign txReady = sel1 ? b_txReady : a_txReady;
   assign rxData  = sel1 ? b_rxData  : a_rxData;
   assign rxValid = sel1 ? b_rxValid : a_rxValid;
   assign done    = sel1 ? b_done    : a_done;
   assign spiCsB  = sel1 ? b_spiCsB  : a_spiCsB;
   assign spiSclk = sel1 ? b_spiSclk : a_spiSclk;
   assign spiMosi = sel1 ? b_spiMosi : a_spiMosi;

   // Flash model: shifts its byte out MSB first, advancing on each SCLK fall.
   assign spiMiso = loopback ? spiMosi : flash_byte[3'd7 - flash_bit];
   always @(negedge spiSclk or posedge spiCsB) begin
      if (spiCsB) flash_bit <= 3'd0;
      else        flash_bit <= flash_bit + 3'd1;
   end

   int n_tests = 0;
   int n_fail = 0;
   int cyc_no = 0, rises = 0, cs_low = 0, cs_falls = 0, dones = 0, rxvs = 0;
   int stall_cyc = 0, stall_bad = 0;
   logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
   bit         mosi_log[$];
   logic [7:0] exp_q[$];
   logic [7:0] tx_bytes[$];

   task automatic tick();
      logic [7:0] e;
      @(posedge sysClk);
      @(negedge sysClk);
      cyc_no++;
      if (spiSclk && !prev_sclk) begin
         rises++;
         mosi_log.push_back(spiMosi);
      end
      if (!spiCsB) cs_low++;
      if (!spiCsB && prev_cs) cs_falls++;
      if (done) dones++;
      if (txReady && !txValid) begin
         stall_cyc++;
         if (spiSclk !== 1'b0 || spiCsB !== 1'b0 || spiMosi !== prev_mosi) stall_bad++;
      end
      if (rxValid) begin
         rxvs++;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_extra: got rxData %h, no byte expected", rxData);
         end else begin
            e = exp_q.pop_front();
            if (rxData !== e) begin
               n_fail++;
               $display("FAIL rx_byte: got %h, expected %h", rxData, e);
            end
         end
      end
      prev_sclk = spiSclk;
      prev_cs   = spiCsB;
      prev_mosi = spiMosi;
   endtask

   task automatic run_txn(input int n, input int stall_idx, input int stall_len,
                          input int pulse_at, input int budget, output bit timeout);
      int sent, stall_left, cyc, d0;
      sent = 0; stall_left = stall_len; cyc = 0; d0 = dones;
      byteCount = 9'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      while (dones == d0 && cyc < budget) begin
         start = (cyc == pulse_at);
         if (sent == stall_idx && stall_left > 0) begin
            txValid = 1'b0;
            stall_left--;
         end else if (sent < n) begin
            txValid = 1'b1;
            txData  = tx_bytes[sent];
         end else begin
            txValid = 1'b0;
         end
         if (txValid && txReady) begin
            exp_q.push_back(loopback ? txData : flash_byte);
            sent++;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      txValid = 1'b0;
      timeout = (dones == d0);
   endtask

   task automatic wait_idle(input int budget, output bit timeout);
      int c;
      c = 0;
      while (busy && c < budget) begin
         tick();
         c++;
      end
      timeout = busy;
   endtask

   task automatic test_reset();
      sysReset_n = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({spiCsB, spiSclk, spiMosi, busy, txReady} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_pins: got cs/sclk/mosi/busy/txr %b, expected 10000",
                  {spiCsB, spiSclk, spiMosi, busy, txReady});
      end
      n_tests++;
      if ({rxValid, done, rxData} !== 10'h000) begin
         n_fail++;
         $display("FAIL reset_rx: got rxv/done/rxData %h, expected 000", {rxValid, done, rxData});
      end
      sysReset_n = 1'b1;
      repeat (2) tick();
      n_tests++;
      if ({spiCsB, busy, rxValid, done} !== 4'b1000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got cs/busy/rxv/done %b, expected 1000",
                  {spiCsB, busy, rxValid, done});
      end
   endtask

   task automatic test_one_byte();
      int r0, c0, d0, v0, m0;
      bit to;
      logic [7:0] mv;
      sel1 = 1'b0; loopback = 1'b0; flash_byte = 8'hA5;
      tx_bytes.delete(); tx_bytes.push_back(8'h9F);
      r0 = rises; c0 = cs_low; d0 = dones; v0 = rxvs; m0 = mosi_log.size();
      run_txn(1, -1, 0, -1, 400, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL one_timeout: got no done, expected done"); end
      mv = 8'h00;
      for (int i = 0; i < 8; i++) mv = {mv[6:0], (m0 + i < mosi_log.size()) ? mosi_log[m0 + i] : 1'b0};
      n_tests++;
      if (mv !== 8'h9F) begin n_fail++; $display("FAIL one_mosi: got %h, expected 9f", mv); end
      n_tests++;
      if (rises - r0 != 8) begin n_fail++; $display("FAIL one_edges: got %0d, expected 8", rises - r0); end
      n_tests++;
      if (rxvs - v0 != 1) begin n_fail++; $display("FAIL one_rxvalid: got %0d, expected 1", rxvs - v0); end
      n_tests++;
      if (dones - d0 != 1) begin n_fail++; $display("FAIL one_done: got %0d, expected 1", dones - d0); end
      // LOAD (1) + 8 bits of 2*CLK_DIV + HOLD of CLK_DIV, with CLK_DIV=2.
      n_tests++;
      if (cs_low - c0 != 35) begin n_fail++; $display("FAIL one_cs_low: got %0d, expected 35", cs_low - c0); end
      n_tests++;
      if (rxData !== 8'hA5) begin n_fail++; $display("FAIL one_rxdata: got %h, expected a5", rxData); end
      wait_idle(50, to);
      n_tests++;
      if (to || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL one_drain: got busy %b pending %0d, expected 0 0", to, exp_q.size());
      end
   endtask

   task automatic test_loopback_256();
      int r0, f0, d0, v0;
      bit to;
      sel1 = 1'b1; loopback = 1'b1;
      tx_bytes.delete();
      for (int i = 0; i < 256; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      r0 = rises; f0 = cs_falls; d0 = dones; v0 = rxvs;
      run_txn(256, -1, 0, -1, 256 * 17 + 100, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL lb_timeout: got no done, expected done"); end
      n_tests++;
      if (rxvs - v0 != 256) begin n_fail++; $display("FAIL lb_rxvalid: got %0d, expected 256", rxvs - v0); end
      n_tests++;
      if (rises - r0 != 2048) begin n_fail++; $display("FAIL lb_edges: got %0d, expected 2048", rises - r0); end
      n_tests++;
      if (cs_falls - f0 != 1 || dones - d0 != 1) begin
         n_fail++;
         $display("FAIL lb_cs_done: got cs %0d done %0d, expected 1 1", cs_falls - f0, dones - d0);
      end
      wait_idle(50, to);
   endtask

   task automatic test_tx_stall();
      int r0, d0, v0, s0, b0;
      bit to;
      sel1 = 1'b1; loopback = 1'b1;
      tx_bytes.delete();
      for (int i = 0; i < 4; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      r0 = rises; d0 = dones; v0 = rxvs; s0 = stall_cyc; b0 = stall_bad;
      run_txn(4, 2, 50, -1, 400, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL stall_timeout: got no done, expected done"); end
      n_tests++;
      if (rises - r0 != 32) begin n_fail++; $display("FAIL stall_edges: got %0d, expected 32", rises - r0); end
      n_tests++;
      if (stall_cyc - s0 < 30) begin n_fail++; $display("FAIL stall_ready: got %0d ready cycles, expected >=30", stall_cyc - s0); end
      n_tests++;
      if (stall_bad != b0) begin n_fail++; $display("FAIL stall_pins: got %0d moving cycles, expected 0", stall_bad - b0); end
      n_tests++;
      if (rxvs - v0 != 4 || dones - d0 != 1) begin
         n_fail++;
         $display("FAIL stall_count: got rxv %0d done %0d, expected 4 1", rxvs - v0, dones - d0);
      end
      wait_idle(50, to);
   endtask

   task automatic test_ignored_starts();
      int f0, d0;
      bit to;
      sel1 = 1'b0; loopback = 1'b1;
      f0 = cs_falls; d0 = dones;
      byteCount = 9'd0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      n_tests++;
      if (cs_falls != f0 || dones != d0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_count: got cs %0d done %0d busy %b, expected 0 0 0", cs_falls - f0, dones - d0, busy);
      end
      tx_bytes.delete(); tx_bytes.push_back(8'h3C);
      run_txn(1, -1, 0, 5, 400, to);
      wait_idle(50, to);
      repeat (20) tick();
      n_tests++;
      if (cs_falls - f0 != 1 || dones - d0 != 1) begin
         n_fail++;
         $display("FAIL busy_start: got cs %0d done %0d, expected 1 1", cs_falls - f0, dones - d0);
      end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL busy_start_rx: got %0d pending, expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_byte();
      int r0, d0, v0, sent, c;
      bit to;
      sel1 = 1'b0; loopback = 1'b1;
      tx_bytes.delete(); tx_bytes.push_back(8'h5A); tx_bytes.push_back(8'hC3);
      r0 = rises; sent = 0; c = 0;
      byteCount = 9'd2; start = 1'b1;
      tick();
      start = 1'b0;
      while (rises - r0 < 12 && c < 200) begin
         txValid = (sent < 2);
         txData  = tx_bytes[(sent < 2) ? sent : 1];
         if (txValid && txReady) begin
            exp_q.push_back(txData);
            sent++;
         end
         tick();
         c++;
      end
      txValid = 1'b0;
      n_tests++;
      if (rises - r0 != 12) begin n_fail++; $display("FAIL rst_reach: got %0d edges, expected 12", rises - r0); end
      n_tests++;
      if (exp_q.size() != 1) begin n_fail++; $display("FAIL rst_pending: got %0d, expected 1", exp_q.size()); end
      exp_q.delete();
      d0 = dones; v0 = rxvs;
      sysReset_n = 1'b0;
      tick();
      n_tests++;
      if ({spiCsB, spiSclk, busy, rxValid, done} !== 5'b10000) begin
         n_fail++;
         $display("FAIL rst_mid: got cs/sclk/busy/rxv/done %b, expected 10000", {spiCsB, spiSclk, busy, rxValid, done});
      end
      repeat (2) tick();
      sysReset_n = 1'b1;
      repeat (5) tick();
      n_tests++;
      if (dones != d0 || rxvs != v0) begin
         n_fail++;
         $display("FAIL rst_quiet: got done %0d rxv %0d, expected 0 0", dones - d0, rxvs - v0);
      end
      tx_bytes.delete(); tx_bytes.push_back(8'hE7);
      run_txn(1, -1, 0, -1, 400, to);
      n_tests++;
      if (to || rxData !== 8'hE7) begin
         n_fail++;
         $display("FAIL rst_after: got timeout %b rxData %h, expected 0 e7", to, rxData);
      end
      wait_idle(50, to);
   endtask

   task automatic test_back_to_back();
      int d0, f0, c, gap, busy_fall, cs2;
      logic pbusy;
      bit to;
      sel1 = 1'b0; loopback = 1'b1;
      d0 = dones; f0 = cs_falls; c = 0; gap = 0; busy_fall = -1; cs2 = -1;
      pbusy = busy;
      byteCount = 9'd1; start = 1'b1;
      while (dones - d0 < 2 && c < 400) begin
         txValid = 1'b1;
         txData  = (dones == d0) ? 8'h81 : 8'h7E;
         if (txValid && txReady) exp_q.push_back(txData);
         tick();
         c++;
         if (dones - d0 == 1 && spiCsB) gap++;
         if (pbusy && !busy && busy_fall < 0) busy_fall = cyc_no;
         if (cs_falls - f0 == 2 && cs2 < 0) cs2 = cyc_no;
         pbusy = busy;
      end
      start = 1'b0; txValid = 1'b0;
      n_tests++;
      if (dones - d0 != 2 || cs_falls - f0 != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got done %0d cs %0d, expected 2 2", dones - d0, cs_falls - f0);
      end
      // Minimum CS-high time is 2*CLK_DIV+1 with CLK_DIV=2.
      n_tests++;
      if (gap != 5) begin n_fail++; $display("FAIL b2b_gap: got %0d, expected 5", gap); end
      n_tests++;
      if (busy_fall < 0 || cs2 - busy_fall != 1) begin
         n_fail++;
         $display("FAIL b2b_restart: got cs fall %0d cycles after busy fall, expected 1", cs2 - busy_fall);
      end
      wait_idle(50, to);
      n_tests++;
      if (to || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got busy %b pending %0d, expected 0 0", to, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_one_byte();
      test_loopback_256();
      test_tx_stall();
      test_ignored_starts();
      test_reset_mid_byte();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
